// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates Q tags at issue, captures CDB results,
// retires one entry per cycle to the regfile, and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [31:0]               issue_pred_pc,
    output logic [Q_WIDTH-1:0]        alloc_tag,
    output logic                      rob_full,
    input  logic                      cdb_valid,
    input  logic [Q_WIDTH-1:0]        cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic [31:0]               cdb_next_pc,
    input  logic [Q_WIDTH-1:0]        query_tag1,
    input  logic [Q_WIDTH-1:0]        query_tag2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,
    output logic                      has_commit,
    output logic [REG_ADDR_WIDTH-1:0] commit_target,
    output logic [Q_WIDTH-1:0]        Commit_Q,
    output logic [31:0]               Commit_V,
    output logic                      store_commit,
    output logic                      control_hazard,
    output logic [31:0]               redirect_pc
);
    localparam int                 DEPTH    = 2 ** Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] LAST     = Q_WIDTH'(DEPTH - 1);
    localparam logic [Q_WIDTH:0]   FULL_CNT = (Q_WIDTH + 1)'(DEPTH - 1);
    localparam logic [1:0]         T_BRANCH = 2'd1;
    localparam logic [1:0]         T_STORE  = 2'd2;

    // Slot 0 exists only so tags index directly; it is never allocated.
    logic                      busy_q    [DEPTH];
    logic                      ready_q   [DEPTH];
    logic                      mispred_q [DEPTH];
    logic [1:0]                type_q    [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_q      [DEPTH];
    logic [31:0]               pred_pc_q [DEPTH];
    logic [31:0]               value_q   [DEPTH];
    logic [31:0]               next_pc_q [DEPTH];

    logic [Q_WIDTH-1:0] head_q, tail_q;
    logic [Q_WIDTH:0]   count_q;
    logic               issue_fire, cdb_fire, commit_fire, flush;

    function automatic logic [Q_WIDTH-1:0] nxt(input logic [Q_WIDTH-1:0] p);
        return (p == LAST) ? Q_WIDTH'(1) : p + 1'b1;
    endfunction

    assign alloc_tag   = tail_q;
    assign rob_full    = (count_q == FULL_CNT);
    assign issue_fire  = issue_valid && !rob_full && !control_hazard;
    assign cdb_fire    = cdb_valid && !control_hazard && busy_q[cdb_tag];
    assign commit_fire = busy_q[head_q] && ready_q[head_q];
    assign flush       = commit_fire && (type_q[head_q] == T_BRANCH) && mispred_q[head_q];

    // Busy gates everything, so tag 0 and retired tags read as not ready.
    function automatic logic [32:0] lookup(input logic [Q_WIDTH-1:0] tag);
        logic [32:0] r;
        r = '0;
        if (busy_q[tag]) begin
            if (ready_q[tag])
                r = {1'b1, value_q[tag]};
            else if (cdb_valid && !control_hazard && cdb_tag == tag)
                r = {1'b1, cdb_value};
        end
        return r;
    endfunction

    always_comb begin
        {query_ready1, query_value1} = lookup(query_tag1);
        {query_ready2, query_value2} = lookup(query_tag2);
    end

    // Payload needs no reset: it is only read once busy/ready say it is valid.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (issue_fire) begin
                type_q[tail_q]    <= issue_type;
                rd_q[tail_q]      <= issue_rd;
                pred_pc_q[tail_q] <= issue_pred_pc;
            end
            if (cdb_fire) begin
                value_q[cdb_tag]   <= cdb_value;
                next_pc_q[cdb_tag] <= cdb_next_pc;
                mispred_q[cdb_tag] <= (type_q[cdb_tag] == T_BRANCH) &&
                                      (cdb_next_pc != pred_pc_q[cdb_tag]);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= Q_WIDTH'(1);
            tail_q         <= Q_WIDTH'(1);
            count_q        <= '0;
            has_commit     <= 1'b0;
            commit_target  <= '0;
            Commit_Q       <= '0;
            Commit_V       <= '0;
            store_commit   <= 1'b0;
            control_hazard <= 1'b0;
            redirect_pc    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (!rdy_in) begin
            has_commit     <= 1'b0;
            store_commit   <= 1'b0;
            control_hazard <= 1'b0;
        end else begin
            has_commit     <= commit_fire && (type_q[head_q] != T_STORE);
            store_commit   <= commit_fire && (type_q[head_q] == T_STORE);
            control_hazard <= flush;
            if (commit_fire && type_q[head_q] != T_STORE) begin
                commit_target <= rd_q[head_q];
                Commit_Q      <= head_q;
                Commit_V      <= value_q[head_q];
            end
            if (flush)
                redirect_pc <= next_pc_q[head_q];
            if (issue_fire) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= nxt(tail_q);
            end
            if (cdb_fire)
                ready_q[cdb_tag] <= 1'b1;
            // Retirement clears after the CDB write so a late duplicate cannot revive it.
            if (commit_fire) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= nxt(head_q);
            end
            count_q <= count_q + (Q_WIDTH + 1)'(issue_fire) - (Q_WIDTH + 1)'(commit_fire);
            if (flush) begin
                head_q  <= Q_WIDTH'(1);
                tail_q  <= Q_WIDTH'(1);
                count_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table for ordered
// retirement and queries, then hand sequences for full/wrap, flush, store, stall, reset.
module tb_reorder_buffer;
    logic        clk_in = 0, rst_in = 1, rdy_in = 1;
    logic        issue_valid = 0;
    logic [1:0]  issue_type = 0;
    logic [4:0]  issue_rd = 0;
    logic [31:0] issue_pred_pc = 0;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        cdb_valid = 0;
    logic [3:0]  cdb_tag = 0;
    logic [31:0] cdb_value = 0, cdb_next_pc = 0;
    logic [3:0]  query_tag1 = 0, query_tag2 = 0;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        has_commit;
    logic [4:0]  commit_target;
    logic [3:0]  Commit_Q;
    logic [31:0] Commit_V;
    logic        store_commit, control_hazard;
    logic [31:0] redirect_pc;

    int checks = 0, failures = 0;

    reorder_buffer #(.REG_ADDR_WIDTH(5), .Q_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_pc(issue_pred_pc), .alloc_tag(alloc_tag), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_next_pc(cdb_next_pc), .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .has_commit(has_commit), .commit_target(commit_target), .Commit_Q(Commit_Q),
        .Commit_V(Commit_V), .store_commit(store_commit),
        .control_hazard(control_hazard), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        iv;
        logic [1:0]  it;
        logic [4:0]  rd;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [3:0]  q1;
        logic [3:0]  e_alloc;
        logic        e_full;
        logic        e_hc;
        logic [4:0]  e_tgt;
        logic [3:0]  e_q;
        logic [31:0] e_v;
        logic        e_qr;
        logic [31:0] e_qv;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; returns at the following negedge where inputs change.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        issue_valid = 0;
        cdb_valid   = 0;
        query_tag1  = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_pred_pc = pc;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic [31:0] npc);
        cdb_valid = 1; cdb_tag = tag; cdb_value = v; cdb_next_pc = npc;
    endtask

    task automatic pulse_reset();
        rst_in = 1;
        #1;
        chk("reset has_commit", 32'(has_commit), 0);
        chk("reset alloc_tag", 32'(alloc_tag), 1);
        rst_in = 0;
    endtask

    initial begin
        //          iv it rd  cv ct cval     q1 alloc full hc tgt q  v        qr qv
        tbl[0]  = '{0, 0, 0,  0, 0, 0,       0, 1,    0,   0, 0,  0, 0,       0, 0};
        tbl[1]  = '{1, 0, 5,  0, 0, 0,       0, 1,    0,   0, 0,  0, 0,       0, 0};
        tbl[2]  = '{1, 0, 6,  0, 0, 0,       0, 2,    0,   0, 0,  0, 0,       0, 0};
        tbl[3]  = '{1, 0, 7,  0, 0, 0,       0, 3,    0,   0, 0,  0, 0,       0, 0};
        tbl[4]  = '{0, 0, 0,  1, 2, 'h22,    2, 4,    0,   0, 0,  0, 0,       1, 'h22};
        tbl[5]  = '{0, 0, 0,  1, 1, 'h11,    2, 4,    0,   0, 0,  0, 0,       1, 'h22};
        tbl[6]  = '{0, 0, 0,  1, 3, 'h33,    0, 4,    0,   0, 0,  0, 0,       0, 0};
        tbl[7]  = '{0, 0, 0,  0, 0, 0,       1, 4,    0,   1, 5,  1, 'h11,    0, 0};
        tbl[8]  = '{0, 0, 0,  0, 0, 0,       3, 4,    0,   1, 6,  2, 'h22,    1, 'h33};
        tbl[9]  = '{0, 0, 0,  0, 0, 0,       0, 4,    0,   1, 7,  3, 'h33,    0, 0};
        tbl[10] = '{0, 0, 0,  1, 0, 'h55,    0, 4,    0,   0, 0,  0, 0,       0, 0};
        tbl[11] = '{1, 0, 8,  0, 0, 0,       4, 4,    0,   0, 0,  0, 0,       0, 0};
        tbl[12] = '{0, 0, 0,  1, 4, 'hABCD,  4, 5,    0,   0, 0,  0, 0,       1, 'hABCD};
        tbl[13] = '{0, 0, 0,  0, 0, 0,       4, 5,    0,   0, 0,  0, 0,       1, 'hABCD};
        tbl[14] = '{0, 0, 0,  0, 0, 0,       0, 5,    0,   1, 8,  4, 'hABCD,  0, 0};
        tbl[15] = '{0, 0, 0,  0, 0, 0,       0, 5,    0,   0, 0,  0, 0,       0, 0};

        @(negedge clk_in);
        #1;
        chk("reset has_commit", 32'(has_commit), 0);
        chk("reset control_hazard", 32'(control_hazard), 0);
        chk("reset Commit_V", Commit_V, 0);
        chk("reset alloc_tag", 32'(alloc_tag), 1);
        chk("reset rob_full", 32'(rob_full), 0);
        rst_in = 0;
        tick();

        // Ordered retirement, CDB bypass and tag-0 queries.
        for (int i = 0; i < 16; i++) begin
            issue_valid = tbl[i].iv; issue_type = tbl[i].it; issue_rd = tbl[i].rd;
            issue_pred_pc = 0;
            cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
            cdb_next_pc = 0;
            query_tag1 = tbl[i].q1;
            #1;
            chk($sformatf("v%0d alloc_tag", i), 32'(alloc_tag), 32'(tbl[i].e_alloc));
            chk($sformatf("v%0d rob_full", i), 32'(rob_full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d has_commit", i), 32'(has_commit), 32'(tbl[i].e_hc));
            chk($sformatf("v%0d store_commit", i), 32'(store_commit), 0);
            chk($sformatf("v%0d control_hazard", i), 32'(control_hazard), 0);
            chk($sformatf("v%0d query_ready1", i), 32'(query_ready1), 32'(tbl[i].e_qr));
            chk($sformatf("v%0d query_value1", i), query_value1, tbl[i].e_qv);
            if (tbl[i].e_hc) begin
                chk($sformatf("v%0d commit_target", i), 32'(commit_target), 32'(tbl[i].e_tgt));
                chk($sformatf("v%0d Commit_Q", i), 32'(Commit_Q), 32'(tbl[i].e_q));
                chk($sformatf("v%0d Commit_V", i), Commit_V, tbl[i].e_v);
            end
            tick();
        end
        idle();

        // Fill to 15, refuse the 16th, retire one, wrap to tag 1.
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            issue(2'd0, 5'(i + 1), 0);
            tick();
        end
        idle();
        #1;
        chk("full rob_full", 32'(rob_full), 1);
        chk("full alloc_tag", 32'(alloc_tag), 1);
        issue(2'd0, 5'd31, 0);
        tick();
        idle();
        #1;
        chk("refused alloc_tag", 32'(alloc_tag), 1);
        chk("refused rob_full", 32'(rob_full), 1);
        cdb(4'd1, 32'h1111, 0);
        tick();
        idle();
        tick();
        #1;
        chk("drain rob_full", 32'(rob_full), 0);
        chk("drain Commit_Q", 32'(Commit_Q), 1);
        chk("wrap alloc_tag", 32'(alloc_tag), 1);
        issue(2'd0, 5'd20, 0);
        tick();
        idle();
        #1;
        chk("wrap next alloc_tag", 32'(alloc_tag), 2);
        chk("refill rob_full", 32'(rob_full), 1);
        cdb(4'd2, 32'h2222, 0);
        tick();
        idle();
        issue(2'd0, 5'd21, 0);
        tick();
        idle();
        #1;
        chk("full+commit alloc_tag", 32'(alloc_tag), 2);
        chk("full+commit has_commit", 32'(has_commit), 1);
        chk("full+commit Commit_V", Commit_V, 32'h2222);
        chk("full+commit rob_full", 32'(rob_full), 0);

        // Mispredicted branch flushes a ready younger entry.
        pulse_reset();
        issue(2'd1, 5'd1, 32'h100);
        tick();
        issue(2'd0, 5'd2, 0);
        tick();
        idle();
        cdb(4'd2, 32'h99, 0);
        tick();
        cdb(4'd1, 32'h104, 32'h200);
        tick();
        idle();
        tick();
        #1;
        chk("br has_commit", 32'(has_commit), 1);
        chk("br commit_target", 32'(commit_target), 1);
        chk("br Commit_V", Commit_V, 32'h104);
        chk("br control_hazard", 32'(control_hazard), 1);
        chk("br redirect_pc", redirect_pc, 32'h200);
        chk("br alloc_tag", 32'(alloc_tag), 1);
        issue(2'd0, 5'd9, 0);
        cdb(4'd1, 32'hDEAD, 0);
        query_tag1 = 4'd2;
        #1;
        chk("hazard query_ready1", 32'(query_ready1), 0);
        tick();
        idle();
        #1;
        chk("post-flush control_hazard", 32'(control_hazard), 0);
        chk("post-flush has_commit", 32'(has_commit), 0);
        chk("hazard issue ignored", 32'(alloc_tag), 1);
        tick();
        #1;
        chk("flushed entry no commit", 32'(has_commit), 0);

        // Store at head retires through store_commit only.
        issue(2'd2, 5'd0, 0);
        tick();
        idle();
        cdb(4'd1, 32'h5, 0);
        tick();
        idle();
        tick();
        #1;
        chk("store store_commit", 32'(store_commit), 1);
        chk("store has_commit", 32'(has_commit), 0);
        tick();
        #1;
        chk("store pulse ends", 32'(store_commit), 0);

        // rdy_in low holds a ready head back.
        issue(2'd0, 5'd3, 0);
        tick();
        idle();
        cdb(4'd2, 32'h77, 0);
        tick();
        idle();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk($sformatf("stall%0d has_commit", i), 32'(has_commit), 0);
            chk($sformatf("stall%0d alloc_tag", i), 32'(alloc_tag), 3);
        end
        rdy_in = 1;
        tick();
        #1;
        chk("resume has_commit", 32'(has_commit), 1);
        chk("resume Commit_Q", 32'(Commit_Q), 2);
        chk("resume Commit_V", Commit_V, 32'h77);

        // Asynchronous reset between clock edges.
        rst_in = 1;
        #1;
        chk("async has_commit", 32'(has_commit), 0);
        chk("async Commit_Q", 32'(Commit_Q), 0);
        chk("async Commit_V", Commit_V, 0);
        chk("async alloc_tag", 32'(alloc_tag), 1);
        rst_in = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Allocates a Q tag per issued instruction and captures results from the CDB.
- Retires one instruction per cycle in program order, driving the register file commit port (has_commit / commit_target / Commit_Q / Commit_V).
- Raises control_hazard on a committed mispredicted branch; control_hazard clears all register-file Q tags and flushes this buffer.

Parameters:
- REG_ADDR_WIDTH, 5, architectural register address width.
- Q_WIDTH, 4, tag width. Tag 0 means "no dependency"; usable tags are 1..2**Q_WIDTH-1, giving 15 entries.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- issue_valid  input  1  allocate an entry this cycle
- issue_type  input  2  0=REG, 1=BRANCH, 2=STORE
- issue_rd  input  REG_ADDR_WIDTH  destination register
- issue_pred_pc  input  32  predicted next PC (BRANCH only)
- alloc_tag  output  Q_WIDTH  tag the next issue receives (tail); also drives regfile Q_value
- rob_full  output  1  no free entry (combinational, count==15)
- cdb_valid  input  1  result broadcast valid
- cdb_tag  input  Q_WIDTH  producing entry
- cdb_value  input  32  result value (link value for BRANCH)
- cdb_next_pc  input  32  actual next PC (BRANCH only)
- query_tag1  input  Q_WIDTH  operand 1 tag lookup
- query_tag2  input  Q_WIDTH  operand 2 tag lookup
- query_ready1 / query_ready2  output  1  entry has a result
- query_value1 / query_value2  output  32  that result
- has_commit  output  1  registered commit pulse to regfile
- commit_target  output  REG_ADDR_WIDTH  rd of the retired entry
- Commit_Q  output  Q_WIDTH  tag of the retired entry
- Commit_V  output  32  value of the retired entry
- store_commit  output  1  pulse: head STORE retired; load/store buffer performs it
- control_hazard  output  1  registered flush pulse
- redirect_pc  output  32  correct PC, valid while control_hazard=1

Behaviour:
- Reset (asynchronous, any time, including mid-flush):
  - head=tail=1, count=0, all entries not busy and not ready.
  - All outputs 0; alloc_tag=1.
- rdy_in=0: no state change. Registered pulses (has_commit, store_commit, control_hazard) drive 0 in that cycle.
- Tag wrap: pointers advance 1→2→…→15→1. Tag 0 is never allocated.
- Issue, on the posedge with issue_valid && !rob_full && !control_hazard:
  - Write entry[tail] = {busy=1, ready=0, type, rd, pred_pc}.
  - Advance tail.
  - issue_valid while full is ignored; the issuer must gate on rob_full.
- CDB write, on the posedge with cdb_valid:
  - If entry[cdb_tag] is busy, set ready=1, value=cdb_value, mispredict=(cdb_next_pc != pred_pc) for BRANCH, and store next_pc.
  - A CDB write to a non-busy tag or to tag 0 is ignored.
- Commit (one per cycle):
  - At a posedge where entry[head] is busy and ready (state before this edge; a CDB write at the same edge commits no earlier than the next edge):
    - REG or BRANCH: has_commit=1, commit_target=rd, Commit_Q=head, Commit_V=value, for one cycle.
    - STORE: store_commit=1, has_commit=0.
    - Clear busy, advance head.
  - Latency: CDB edge N → commit pulse visible after edge N+1.
- Mispredict:
  - Committing a BRANCH with mispredict=1 also asserts control_hazard=1 and redirect_pc=next_pc for one cycle (has_commit still 1 for the link write).
  - At the same edge, flush all later entries: head=tail=1, count=0, all busy cleared.
  - While control_hazard=1, issue and CDB inputs are ignored; the regfile discards its commit in that cycle, by its own rules.
- Simultaneous issue and commit: count unchanged. A full buffer with a commit still refuses issue that cycle (rob_full is based on current count).
- Query: combinational.
  - query_ready = entry[tag].ready || (cdb_valid && cdb_tag==tag), with CDB bypass of the value.
  - Tag 0 or a non-busy tag gives ready=0, value=0.

Test Plan:
- Reset then issue 3 REG ops rd=5,6,7 → tags 1,2,3. CDB tag2 value=0x22 first, then tag1 0x11, tag3 0x33 → commits strictly ordered: (rd5,Q1,0x11), (rd6,Q2,0x22), (rd7,Q3,0x33), one per cycle.
- Issue 15 ops → rob_full=1, a 16th issue is ignored. Commit one → rob_full=0; the next issue gets tag 1 (wrap).
- BRANCH with pred_pc=0x100, CDB next_pc=0x200 value=0x104 rd=1:
  - Commit cycle: has_commit=1, Commit_V=0x104, control_hazard=1, redirect_pc=0x200.
  - Next cycle: count=0, alloc_tag=1.
- Query tag 4 while cdb_valid with tag 4 and value 0xABCD → query_ready1=1 and query_value1=0xABCD in the same cycle. Query tag 0 → ready=0.
- STORE at head becomes ready → store_commit=1, has_commit=0.
- rdy_in low for 3 cycles with a ready head → no commit occurs. Assert rst_in mid-stream → outputs 0 immediately, without waiting for a clock edge.
